// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 matrix multiplier front end:
// element/operand widths and the operand loader state encoding.
package matmul_pkg;

  localparam int ELEM_W  = 8;
  localparam int MAT_DIM = 2;
  localparam int MAT_W   = MAT_DIM * MAT_DIM * ELEM_W;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Element stream in, packed operand pair out, plus the loader's framing
// error pulse and a state view for checkers.
interface matrix_operand_loader_if #(
  parameter int ELEM_W = 8
);
  import matmul_pkg::*;

  // Both channels are strict valid/ready: a transfer happens on a rising edge
  // where valid && ready; valid never waits for ready, ready never looks at valid.
  logic [ELEM_W-1:0]   in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [4*ELEM_W-1:0] mat_a;
  logic [4*ELEM_W-1:0] mat_b;
  logic                out_valid;
  logic                out_ready;
  logic                frame_err;
  state_t              dbg_state;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, mat_a, mat_b, out_valid, frame_err, dbg_state
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, mat_a, mat_b, out_valid, frame_err, dbg_state
  );

endinterface

// File: rtl/matrix_stage_reg.sv
// Operand word register with load enable; holds its value until the next load.
module matrix_stage_reg #(
  parameter int W = matmul_pkg::MAT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Collects an 8-element frame (A row-major, then B row-major), checks its
// framing against in_last and presents the packed operands until accepted.
module matrix_operand_loader #(
  parameter int ELEM_W = matmul_pkg::ELEM_W
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic                     clear,
  matrix_operand_loader_if.slave  bus
);
  import matmul_pkg::*;

  localparam int OP_W     = MAT_DIM * MAT_DIM * ELEM_W;
  localparam int NUM_ELEM = 2 * MAT_DIM * MAT_DIM;

  state_t            state_q, state_d;
  logic [2:0]        idx_q;
  logic [ELEM_W-1:0] staging_q [NUM_ELEM];
  logic              out_valid_q;
  logic              frame_err_q;

  logic              in_ready_c;
  logic              beat;
  logic              last_slot;
  logic              good_end;
  logic              bad_end;
  logic [OP_W-1:0]   next_a;
  logic [OP_W-1:0]   next_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          if (beat && last_slot) state_d = bus.in_last ? HOLD : DRAIN;
        end
        DRAIN: begin
          if (beat && bus.in_last) state_d = LOAD;
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) state_d = LOAD;
        end
        default: state_d = LOAD;
      endcase
    end
  end

  // Output decode: ready comes from the registered state alone
  always_comb begin
    in_ready_c = (state_q != HOLD);
    beat       = bus.in_valid && in_ready_c;
    last_slot  = (idx_q == 3'd7);
    good_end   = !clear && (state_q == LOAD) && beat && bus.in_last && last_slot;
    bad_end    = !clear && (state_q == LOAD) && beat && (bus.in_last != last_slot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NUM_ELEM; i++) staging_q[i] <= '0;
    end else begin
      frame_err_q <= bad_end;
      if (clear) begin
        idx_q       <= '0;
        out_valid_q <= 1'b0;
      end else begin
        if (state_q == LOAD && beat) begin
          staging_q[idx_q] <= bus.in_data;
          idx_q <= (bus.in_last || last_slot) ? 3'd0 : idx_q + 3'd1;
        end
        if (good_end) begin
          out_valid_q <= 1'b1;
        end else if (state_q == HOLD && bus.out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  // The 8th element goes straight from the bus into the B word
  assign next_a = {staging_q[0], staging_q[1], staging_q[2], staging_q[3]};
  assign next_b = {staging_q[4], staging_q[5], staging_q[6], bus.in_data};

  matrix_stage_reg #(.W(OP_W)) u_reg_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (good_end),
    .d     (next_a),
    .q     (bus.mat_a)
  );

  matrix_stage_reg #(.W(OP_W)) u_reg_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (good_end),
    .d     (next_b),
    .q     (bus.mat_b)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed and randomized frames against a frame-level model of the loader.
module tb_matrix_operand_loader;
  import matmul_pkg::*;

  localparam int EW = 8;
  localparam int OW = 4 * EW;

  logic clk;
  logic rst_n;
  logic clear;

  matrix_operand_loader_if #(.ELEM_W(EW)) bus ();

  matrix_operand_loader #(.ELEM_W(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  int vectors;
  int miscompares;
  int err_seen;
  int exp_err;
  logic [EW-1:0]   frame_q [$];
  logic [2*OW-1:0] exp_q [$];
  logic [OW-1:0]   last_a;
  logic [OW-1:0]   last_b;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_err === 1'b1) err_seen++;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic send_beat(input logic [EW-1:0] d, input logic last);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      cycle();
      guard++;
    end
    if (guard >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, guard);
    end
    cycle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic make_seq(input int start, input int len);
    frame_q.delete();
    for (int i = 0; i < len; i++) frame_q.push_back(EW'(start + i));
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < frame_q.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) cycle();
      send_beat(frame_q[i], (i == frame_q.size() - 1));
    end
  endtask

  // Reference model: a frame is good exactly when it has 8 elements
  function automatic logic [2*OW-1:0] model_ops();
    logic [2*OW-1:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[2*OW-EW-1:0], frame_q[i]};
    return v;
  endfunction

  task automatic model_frame();
    if (frame_q.size() == 8) begin
      exp_q.push_back(model_ops());
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_ops(input string name);
    logic [2*OW-1:0] e;
    e = exp_q.pop_front();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.mat_a !== e[2*OW-1:OW] || bus.mat_b !== e[OW-1:0]) begin
      miscompares++;
      $display("FAIL %s: out_valid=%b a=%h b=%h, required 1 a=%h b=%h",
               name, bus.out_valid, bus.mat_a, bus.mat_b, e[2*OW-1:OW], e[OW-1:0]);
    end
    last_a = e[2*OW-1:OW];
    last_b = e[OW-1:0];
  endtask

  task automatic check_unchanged(input string name);
    vectors++;
    if (bus.mat_a !== last_a || bus.mat_b !== last_b) begin
      miscompares++;
      $display("FAIL %s: a=%h b=%h, required a=%h b=%h", name, bus.mat_a, bus.mat_b, last_a, last_b);
    end
  endtask

  task automatic check_errs(input string name);
    vectors++;
    if (err_seen != exp_err) begin
      miscompares++;
      $display("FAIL %s: frame_err pulses=%0d, required %0d", name, err_seen, exp_err);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    vectors++;
    if (bus.mat_a !== '0 || bus.mat_b !== '0 || bus.out_valid !== 1'b0 ||
        bus.frame_err !== 1'b0 || bus.in_ready !== 1'b1 || bus.dbg_state !== LOAD) begin
      miscompares++;
      $display("FAIL reset: a=%h b=%h ov=%b fe=%b ir=%b st=%0d, required 0 0 0 0 1 0",
               bus.mat_a, bus.mat_b, bus.out_valid, bus.frame_err, bus.in_ready, bus.dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_good_frame();
    bus.out_ready = 1'b1;
    make_seq(1, 8);
    model_frame();
    send_frame(0);
    check_ops("good_frame_ops");
    check_bit("good_frame_bubble", bus.in_ready, 1'b0);
    cycle();
    check_bit("good_frame_ov_drop", bus.out_valid, 1'b0);
    check_bit("good_frame_ready_back", bus.in_ready, 1'b1);
  endtask

  task automatic test_hold_stall();
    bus.out_ready = 1'b0;
    make_seq(1, 8);
    model_frame();
    send_frame(1);
    check_ops("stall_ops");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_bit("stall_ov_held", bus.out_valid, 1'b1);
      check_bit("stall_in_ready_low", bus.in_ready, 1'b0);
      check_unchanged("stall_ops_stable");
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    check_bit("stall_release", bus.out_valid, 1'b0);
    make_seq(8'h1F, 8);
    model_frame();
    send_frame(0);
    check_ops("stall_offer_not_captured");
    cycle();
  endtask

  task automatic test_early_last();
    make_seq(8'h70, 3);
    model_frame();
    send_frame(0);
    check_bit("early_last_err", bus.frame_err, 1'b1);
    check_unchanged("early_last_keep");
    cycle();
    check_errs("early_last_count");
    make_seq(8'h0A, 8);
    model_frame();
    send_frame(0);
    check_ops("early_last_recover");
    cycle();
  endtask

  task automatic test_long_frame();
    make_seq(8'h40, 10);
    model_frame();
    for (int i = 0; i < 10; i++) begin
      send_beat(frame_q[i], i == 9);
      if (i == 7) begin
        check_bit("long_err_at_8", bus.frame_err, 1'b1);
        check_bit("long_drain_ready", bus.in_ready, 1'b1);
      end
    end
    check_bit("long_no_ov", bus.out_valid, 1'b0);
    check_unchanged("long_keep");
    cycle();
    check_errs("long_count");
    make_seq(8'h50, 8);
    model_frame();
    send_frame(0);
    check_ops("long_recover");
    cycle();
  endtask

  task automatic test_clear();
    make_seq(8'h60, 5);
    for (int i = 0; i < 5; i++) send_beat(frame_q[i], 1'b0);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check_unchanged("clear_keep");
    make_seq(8'h15, 8);
    model_frame();
    send_frame(0);
    check_ops("clear_frame");
    cycle();
    check_errs("clear_no_err");
  endtask

  task automatic test_async_reset();
    make_seq(8'h80, 3);
    for (int i = 0; i < 3; i++) send_beat(frame_q[i], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    last_a = '0;
    last_b = '0;
    check_unchanged("rst_mid_ops_zero");
    check_bit("rst_mid_ov", bus.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check_bit("rst_mid_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b0;
    make_seq(8'h90, 8);
    model_frame();
    send_frame(0);
    check_ops("rst_mid_fresh_frame");
    #2 rst_n = 1'b0;
    #1;
    last_a = '0;
    last_b = '0;
    check_unchanged("rst_hold_ops_zero");
    check_bit("rst_hold_ov", bus.out_valid, 1'b0);
    check_bit("rst_hold_fe", bus.frame_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check_bit("rst_hold_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 60; f++) begin
      len = ($urandom_range(0, 1) == 1) ? 8 : $urandom_range(1, 11);
      frame_q.delete();
      for (int i = 0; i < len; i++) frame_q.push_back(EW'($urandom_range(0, 255)));
      model_frame();
      bus.out_ready = (len == 8) ? 1'b0 : 1'b1;
      send_frame(2);
      if (len == 8) begin
        check_ops("rand_ops");
        repeat ($urandom_range(0, 3)) begin
          cycle();
          check_unchanged("rand_hold_stable");
        end
        bus.out_ready = 1'b1;
        cycle();
        check_bit("rand_release", bus.out_valid, 1'b0);
      end else begin
        check_unchanged("rand_bad_keep");
        cycle();
      end
      check_errs("rand_err_count");
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    err_seen      = 0;
    exp_err       = 0;
    last_a        = '0;
    last_b        = '0;
    clear         = 1'b0;
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_good_frame();
    test_hold_stall();
    test_early_last();
    test_long_frame();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
